inc_pulse_debouncer: RTL
========================

// Module: inc_pulse_debouncer
// PURPOSE
//  Conditions a raw, asynchronous, bouncy push-button or strobe into clean single-cycle pulses.
//  Sits directly upstream of the 16-bit up-counter and drives its `inc` input from O_rise.
//  Pipeline: 2-flop synchroniser -> stability counter -> committed level -> edge pulses.
//  Guarantee: one debounced press gives exactly one counter increment.
// PARAMETERS
//  STABLE_CYCLES  default 1000  consecutive sync cycles a new level must hold before commit; legal range 1..65535
//  CNT_W          default 16    stability counter width; must satisfy 2**CNT_W > STABLE_CYCLES-1
// PORTS
//  CLK      input   1  single clock, rising edge
//  RESET    input   1  synchronous, active-high reset
//  I        input   1  raw asynchronous input
//  O_level  output  1  debounced, committed level
//  O_rise   output  1  one-cycle pulse on committed 0->1 transition; connects to counter inc
//  O_fall   output  1  one-cycle pulse on committed 1->0 transition
// BEHAVIOUR
//  - Sync and active-high reset; RESET dominates all other logic. Mid-operation reset has the same effect.
//    On the next CLK edge: sync1/sync2 cleared, state=0, cnt=0, O_level=0, O_rise=0, O_fall=0.
//  - Synchroniser: sync1<=I, sync2<=sync1. Its values are never observed directly. No ports go combinationally from I to any output.
//  - Stability counter, evaluated each edge when RESET=0:
//    . sync2==state: cnt<=0.
//    . sync2!=state and cnt<STABLE_CYCLES-1: cnt<=cnt+1.
//    . sync2!=state and cnt==STABLE_CYCLES-1 (commit): state<=sync2, cnt<=0.
//  - Outputs, all registered:
//    . O_level = state.
//    . O_rise is 1 for exactly the cycle after a commit to 1; otherwise 0.
//    . O_fall is 1 for exactly the cycle after a commit to 0; otherwise 0.
//    . O_level and its pulse change on the same CLK edge.
//    . O_rise and O_fall are never both 1.
//  - Latency: I stable from just before edge 0. O_level/pulse update on edge STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges.
//  - Glitch rejection: a mismatch lasting < STABLE_CYCLES consecutive sync cycles returns cnt to 0. No output changes.
//    A bounce restarts qualification from 0.
//  - Minimum spacing: consecutive pulses are >= STABLE_CYCLES cycles apart. Downstream never sees back-to-back inc.
//  - cnt never exceeds STABLE_CYCLES-1, so there is no wrap. STABLE_CYCLES=1 commits on the first mismatched cycle.
//  - Input held high through reset: after release it re-qualifies as a new press.
//    O_rise fires STABLE_CYCLES+2 edges after the first non-reset edge.
// STRUCTURE
//  - Shared package debounce_pkg: DEFAULT_STABLE_CYCLES=1000, and a clog2 helper used to derive CNT_W.
//  - One sub-module: sync_2ff (1-bit, sync reset to 0), reused by other async input paths.
//  - Remainder is flat: stability counter, state flop, two pulse flops.
// TESTING  (run with STABLE_CYCLES=4, counter downstream with init 0)
//  1. RESET=1 for 3 cycles with I=1 -> all outputs 0 during reset.
//     Release; O_level/O_rise go to 1 on the 6th edge. O_rise is high 1 cycle; counter O=1.
//  2. From O_level=0, I pulses high for 3 cycles then low -> no commit, O_rise never asserts, counter stays 0.
//  3. Bounce 1,0,1,0 then steady 1 for 10 cycles.
//     Exactly one O_rise, 6 edges after steady 1 begins; counter +1.
//  4. Five clean press/release pairs, each level held 8 cycles.
//     5 O_rise and 5 O_fall pulses, never overlapping; counter O=5.
//  5. Assert RESET for 1 cycle during qualification (cnt=2) with I=1 -> cnt=0.
//     Rise lands 6 edges after release, not earlier.
//  6. Random I for 10k cycles vs. reference model -> outputs match cycle-exact.
//     Assert O_rise & O_fall is never 1; assert pulse spacing >= 4.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and elaboration helpers for debouncer-style input conditioning.
package debounce_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 1000;
  localparam int DEFAULT_CNT_W         = 16;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2_fn(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/inc_pulse_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronously cleared to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q;
  logic sync1_d;
  logic sync2_q;
  logic sync2_d;

  // Next-state of the synchroniser chain.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/inc_pulse_debouncer.sv
// Debounces a raw asynchronous input into a committed level plus one-cycle rise/fall pulses.
import debounce_pkg::*;

module inc_pulse_debouncer #(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  input  logic I,
  output logic O_level,
  output logic O_rise,
  output logic O_fall
);

  // Never narrower than what STABLE_CYCLES-1 needs, and at least one bit.
  localparam int REQ_W = clog2_fn(STABLE_CYCLES);
  localparam int CW0   = (CNT_W > REQ_W) ? CNT_W : REQ_W;
  localparam int CW    = (CW0 > 0) ? CW0 : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);

  logic          i_sync;
  logic          state_q;
  logic          state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (I),
    .q   (i_sync)
  );

  // Stability qualification and commit of a new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (i_sync != state_q) begin
      if (cnt_q == CNT_TERM) begin
        state_d = i_sync;
        cnt_d   = '0;
        rise_d  = i_sync;
        fall_d  = ~i_sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Committed level, counter and pulse flops; pulses land on the same edge as the level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign O_level = state_q;
  assign O_rise  = rise_q;
  assign O_fall  = fall_q;

endmodule
